nn_run_scheduler: RTL
=====================

# nn_run_scheduler

Top-level run controller for the binary NN accelerator. It owns the shared W/X memory ports and hands them either to the host loader (weight/input download) or to the XNOR-popcount compute engine. It sequences each inference: engine reset, enable, wait for `compute_finish`, timeout watchdog, completion report. It sits between the host-side loader, the compute engine and the W/X memory macros.

## Interface
Parameters:
- `W_ADDR_LEN`, 20: W memory address width
- `X_ADDR_LEN`, 10: X memory address width
- `W_SEL_LEN`, 2: W bank select width
- `X_SEL_LEN`, 2: X bank select width
- `CNT_LEN`, 24: run-cycle counter / timeout width
- `TIMEOUT`, 24'hFFFFF0: max RUN cycles before abort; must be ≥ 2

Ports (one clock; reset is asynchronous and active-high, named `rst`; clock is `clk`):
- `clk` in 1: clock
- `rst` in 1: async active-high reset
- `start` in 1: request one inference; level sampled at posedge
- `busy` out 1: high from start acceptance until done pulse
- `done` out 1: one-cycle completion pulse
- `error` out 1: sticky timeout flag; cleared on next accepted start
- `run_cycles` out CNT_LEN: RUN cycles of last inference
- `ld_req` in 1: loader requests memory ownership
- `ld_gnt` out 1: loader owns memories
- `ld_w_addr` in W_ADDR_LEN, `ld_w_sel` in W_SEL_LEN, `ld_w_wq` in 1: loader W port
- `ld_x_addr` in X_ADDR_LEN, `ld_x_sel` in X_SEL_LEN, `ld_x_wq` in 1: loader X port
- `ld_wx_write` in 1: loader write data bit
- `ce_en` out 1: engine enable (engine resets while low)
- `ce_finish` in 1: engine `compute_finish`
- `ce_w_addr` in W_ADDR_LEN, `ce_w_sel` in W_SEL_LEN, `ce_w_wq` in 1: engine W port
- `ce_x_addr` in X_ADDR_LEN, `ce_x_sel` in X_SEL_LEN, `ce_x_wq` in 1: engine X port
- `ce_wx_write` in 1: engine write data bit
- `mem_w_addr` out W_ADDR_LEN, `mem_w_sel` out W_SEL_LEN, `mem_w_wq` out 1: muxed W port
- `mem_x_addr` out X_ADDR_LEN, `mem_x_sel` out X_SEL_LEN, `mem_x_wq` out 1: muxed X port
- `mem_wx_write` out 1: muxed write data

## Operation
- States: IDLE, LOAD, ARM, RUN, DONE.
- IDLE: if `ld_req` → LOAD (loader priority). Else if `start` or `pend` → ARM, clear `error`, `pend`, `run_cycles`.
- `pend` register: `start` seen while not in IDLE, or in IDLE together with `ld_req`, sets `pend`. It is served on the next IDLE with `ld_req` low.
- LOAD: `ld_gnt`=1. Exit to IDLE when `ld_req`=0.
- ARM: `ce_en`=0 for exactly one cycle (engine sync reset), then RUN.
- RUN: `ce_en`=1. `run_cycles` increments each cycle, saturating at all-ones.
  - `ce_finish`=1 → DONE.
  - `run_cycles` == TIMEOUT-1 without finish → set `error`, DONE.
  - Finish wins over timeout when both occur in the same cycle.
- DONE: `ce_en`=0, `done`=1 for one cycle, then IDLE.
- Port mux: in LOAD all `mem_*` come from `ld_*`; in every other state from `ce_*`.
- Write gating: `mem_w_wq`/`mem_x_wq` pass through only in LOAD (loader) or RUN (engine), and are forced 0 otherwise.
- `ld_*` activity outside LOAD is ignored. `ce_finish` outside RUN is ignored.
- `busy` = state ∈ {ARM, RUN, DONE}. `ld_gnt` = state==LOAD.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `error` 0, `run_cycles` 0, `ld_gnt` 0, `ce_en` 0, `pend` 0. All `mem_*` follow `ce_*` with both wq forced 0.
- `rst` asserted mid-run: `ce_en` drops asynchronously, and the in-flight inference is lost with no `done`.
- All outputs except the `mem_*` mux are registered.
- `mem_*` is combinational from the current state and the selected source, giving zero-cycle address latency.
- `start` in IDLE at edge N: ARM at N+1 (`busy`=1), RUN at N+2 (`ce_en`=1).
- `ce_finish` seen at edge M in RUN: DONE at M+1 (`done`=1, `ce_en`=0), IDLE at M+2.
- `run_cycles` = number of RUN-state edges before exit.
- `ld_req` in IDLE at edge N: `ld_gnt` at N+1. `ld_req` dropped at edge K: IDLE at K+1. A pending start reaches ARM at K+2.
- Back-to-back: `start` held high through DONE launches the next run from IDLE with no extra gap beyond the IDLE cycle.

## Test plan
- Reset, then `start` pulse with `ce_finish` raised after 100 RUN cycles → `ce_en` high for exactly 100 cycles, `done` pulse one cycle later, `run_cycles`=100, `error`=0.
- `ld_req` high for 20 cycles with `ld_x_wq` toggling → `mem_x_wq` mirrors it only while `ld_gnt`=1. During RUN, `ld_x_wq`=1 → `mem_x_wq`=0.
- `start` and `ld_req` in the same IDLE cycle → LOAD first, ARM two cycles after `ld_req` drops, `busy` low until then.
- Parameter TIMEOUT=16, `ce_finish` never asserted → `ce_en` high 16 cycles, `error`=1, `done` pulse. The next `start` clears `error`.
- `ce_finish` on the same cycle as the timeout terminal count → `error`=0.
- `rst` asserted during RUN at cycle 50 → `ce_en`=0 immediately, no `done`, all outputs at reset values, and a fresh `start` runs normally.

Source files
------------

// File: rtl/nn_run_scheduler.sv
// nn_run_scheduler: run controller for the binary NN accelerator; arbitrates the shared W/X memory ports.
// Latency: start->ARM 1 cycle, ARM->RUN 1 cycle, finish/timeout->DONE 1 cycle, DONE->IDLE 1 cycle.
// Backpressure: start is never dropped (latched as pending while busy or loading); the loader has priority over starts.
module nn_run_scheduler #(
  parameter int                 W_ADDR_LEN = 20,
  parameter int                 X_ADDR_LEN = 10,
  parameter int                 W_SEL_LEN  = 2,
  parameter int                 X_SEL_LEN  = 2,
  parameter int                 CNT_LEN    = 24,
  parameter logic [CNT_LEN-1:0] TIMEOUT    = 24'hFFFFF0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_LEN-1:0]    run_cycles,
  input  logic                  ld_req,
  output logic                  ld_gnt,
  input  logic [W_ADDR_LEN-1:0] ld_w_addr,
  input  logic [W_SEL_LEN-1:0]  ld_w_sel,
  input  logic                  ld_w_wq,
  input  logic [X_ADDR_LEN-1:0] ld_x_addr,
  input  logic [X_SEL_LEN-1:0]  ld_x_sel,
  input  logic                  ld_x_wq,
  input  logic                  ld_wx_write,
  output logic                  ce_en,
  input  logic                  ce_finish,
  input  logic [W_ADDR_LEN-1:0] ce_w_addr,
  input  logic [W_SEL_LEN-1:0]  ce_w_sel,
  input  logic                  ce_w_wq,
  input  logic [X_ADDR_LEN-1:0] ce_x_addr,
  input  logic [X_SEL_LEN-1:0]  ce_x_sel,
  input  logic                  ce_x_wq,
  input  logic                  ce_wx_write,
  output logic [W_ADDR_LEN-1:0] mem_w_addr,
  output logic [W_SEL_LEN-1:0]  mem_w_sel,
  output logic                  mem_w_wq,
  output logic [X_ADDR_LEN-1:0] mem_x_addr,
  output logic [X_SEL_LEN-1:0]  mem_x_sel,
  output logic                  mem_x_wq,
  output logic                  mem_wx_write
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Value of the run counter on the last RUN edge a timed-out inference may spend.
  localparam logic [CNT_LEN-1:0] TERM_CNT = TIMEOUT - {{(CNT_LEN-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic                 pend_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic                 ld_gnt_q;
  logic                 ce_en_q;
  logic [CNT_LEN-1:0]   run_cycles_q;

  // Sequencer: state plus every registered output, all updated from the transition taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ld_gnt_q     <= 1'b0;
      ce_en_q      <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      done_q <= 1'b0;
      // A start that cannot be accepted right now is remembered, never dropped.
      if (start && (state_q != S_IDLE)) pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (ld_req) begin
            state_q  <= S_LOAD;
            ld_gnt_q <= 1'b1;
            if (start) pend_q <= 1'b1;
          end else if (start || pend_q) begin
            state_q      <= S_ARM;
            busy_q       <= 1'b1;
            error_q      <= 1'b0;
            pend_q       <= 1'b0;
            run_cycles_q <= '0;
          end
        end
        S_LOAD: begin
          if (!ld_req) begin
            state_q  <= S_IDLE;
            ld_gnt_q <= 1'b0;
          end
        end
        S_ARM: begin
          // One cycle with ce_en low gives the engine its synchronous reset.
          state_q <= S_RUN;
          ce_en_q <= 1'b1;
        end
        S_RUN: begin
          if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 1'b1;
          if (ce_finish || (run_cycles_q == TERM_CNT)) begin
            state_q <= S_DONE;
            ce_en_q <= 1'b0;
            done_q  <= 1'b1;
            // Finish wins a tie with the terminal count.
            if (!ce_finish) error_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          ld_gnt_q <= 1'b0;
          ce_en_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory port mux: loader owns the ports only in LOAD; writes pass only in LOAD or RUN.
  always_comb begin
    mem_w_addr   = ce_w_addr;
    mem_w_sel    = ce_w_sel;
    mem_x_addr   = ce_x_addr;
    mem_x_sel    = ce_x_sel;
    mem_wx_write = ce_wx_write;
    mem_w_wq     = 1'b0;
    mem_x_wq     = 1'b0;
    if (state_q == S_LOAD) begin
      mem_w_addr   = ld_w_addr;
      mem_w_sel    = ld_w_sel;
      mem_x_addr   = ld_x_addr;
      mem_x_sel    = ld_x_sel;
      mem_wx_write = ld_wx_write;
      mem_w_wq     = ld_w_wq;
      mem_x_wq     = ld_x_wq;
    end else if (state_q == S_RUN) begin
      mem_w_wq = ce_w_wq;
      mem_x_wq = ce_x_wq;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign run_cycles = run_cycles_q;
  assign ld_gnt     = ld_gnt_q;
  assign ce_en      = ce_en_q;

endmodule
